ex_muldiv_seq: RTL and testbench

- Sequencer for a shared iterative RV32M multiply/divide unit beside the Execute stage ALU.
- Accepts one M-extension op at a time, holds the pipeline while it iterates, and returns the result with its destination register to the EX/MEM boundary.
- Contains the FSM, the iteration counter and a radix-2 shift/add–subtract datapath.

---
 rtl/ex_muldiv_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_seq
// Description : Sequencer for a shared iterative RV32M multiply/divide unit
//               sitting beside the Execute-stage ALU. One M-extension op is
//               accepted at a time. The pipeline is held while the unit
//               iterates (radix-2 shift/add for multiply, restoring
//               shift/subtract for divide). The result and its destination
//               register are then returned to the EX/MEM boundary with a
//               one-cycle Done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   Start        in   issue pulse for an M-extension op
//   Funct3       in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   ReadData1in  in   rs1 operand
//   ReadData2in  in   rs2 operand
//   WriteRegIn   in   destination register of the issued op
//   Flush        in   abort the in-flight op (branch/jump squash)
//   Stall        out  freeze IF/ID/EX pipeline registers
//   Busy         out  an op is in progress
//   Done         out  one-cycle result-valid pulse
//   ResultOut    out  result, valid while Done=1, held until the next Done
//   WriteRegOut  out  destination register of the completed op
//   RegWriteOut  out  register write enable (same as Done)
// ----------------------------------------------------------------------------
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies finish in PREP through a
//                       combinational signed multiplier (PREP -> DONE).
//                       Divides are unaffected.
// ============================================================================
module ex_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] ReadData1in,
  input  logic [XLEN-1:0] ReadData2in,
  input  logic [REGW-1:0] WriteRegIn,
  input  logic            Flush,
  output logic            Stall,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] ResultOut,
  output logic [REGW-1:0] WriteRegOut,
  output logic            RegWriteOut
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic [2:0]        r_funct3;
  logic [REGW-1:0]   r_rd;
  logic              r_sa;      // rs1 negative and treated as signed
  logic              r_sb;      // rs2 negative and treated as signed
  logic [XLEN-1:0]   r_mag;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc;     // {high, low} working register
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [REGW-1:0]   r_wreg;

  // ------------------------------------------------------------------
  // Operand decode (used in PREP on the captured operands)
  // ------------------------------------------------------------------
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (r_funct3)
      3'd1, 3'd4, 3'd6: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'd2: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg    = w_a_signed & r_op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & r_op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -r_op_a : r_op_a;
  assign w_mag_b    = w_b_neg ? -r_op_b : r_op_b;
  assign w_is_div   = r_funct3[2];
  assign w_div_zero = w_is_div & (r_op_b == '0);
  // Only the signed divides can overflow (INT_MIN / -1).
  assign w_div_ovf  = w_is_div & w_b_signed &
                      (r_op_a == C_INT_MIN) & (r_op_b == '1);

  // Funct3[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = r_funct3[1] ? r_op_a : '1;
    end else begin
      w_special_res = r_funct3[1] ? '0 : C_INT_MIN;
    end
  end

  // ------------------------------------------------------------------
  // Iteration datapath
  // ------------------------------------------------------------------
  // Multiply: the multiplier sits in the low half of r_acc and is
  // consumed LSB first while partial sums shift in from the top.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_mag} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: remainder in the high half, dividend bits shift out of the
  // low half while quotient bits shift in behind them.
  logic [XLEN:0]     w_top;
  logic              w_fits;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_div_next;

  assign w_top      = r_acc[2*XLEN-1:XLEN-1];
  assign w_fits     = (w_top >= {1'b0, r_mag});
  // When it fits the difference is below r_mag, so XLEN bits suffice.
  assign w_sub      = w_top[XLEN-1:0] - r_mag;
  assign w_div_next = w_fits ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                             : {w_top[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  // ------------------------------------------------------------------
  // Sign fix-up and result selection
  // ------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (w_is_div) begin
      w_fix_res = r_funct3[1] ? w_rem : w_quot;
    end else if (r_funct3 == 3'd0) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending to 2*XLEN gives the same low 2*XLEN bits as a
  // (XLEN+1)x(XLEN+1) signed product, which is all that is selected.
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_a    = {{XLEN{w_a_neg}}, r_op_a};
  assign w_fast_b    = {{XLEN{w_b_neg}}, r_op_b};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_res  = (r_funct3[1:0] == 2'd0) ? w_fast_prod[XLEN-1:0]
                                               : w_fast_prod[2*XLEN-1:XLEN];
`endif

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_wreg   <= '0;
    end else begin
      r_done <= 1'b0;
      if (Flush) begin
        // Squash wins over everything, including a same-cycle Start.
        // A Done already on the outputs has been delivered.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_op_a   <= ReadData1in;
              r_op_b   <= ReadData2in;
              r_funct3 <= Funct3;
              r_rd     <= WriteRegIn;
              r_state  <= S_PREP;
            end
          end
          S_PREP: begin
            r_sa  <= w_a_neg;
            r_sb  <= w_b_neg;
            r_cnt <= CW'(XLEN - 1);
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special_res;
              r_wreg   <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_is_div) begin
              r_result <= w_fast_res;
              r_wreg   <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`endif
            end else if (w_is_div) begin
              r_mag   <= w_mag_b;
              r_acc   <= {{XLEN{1'b0}}, w_mag_a};
              r_state <= S_CALC;
            end else begin
              r_mag   <= w_mag_a;
              r_acc   <= {{XLEN{1'b0}}, w_mag_b};
              r_state <= S_CALC;
            end
          end
          S_CALC: begin
            r_acc <= w_is_div ? w_div_next : w_mul_next;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_FIX: begin
            r_result <= w_fix_res;
            r_wreg   <= r_rd;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Stall is combinational on Start in IDLE so the issuing instruction
  // is held in EX during the very cycle it is presented.
  assign Stall = (r_state == S_PREP) || (r_state == S_CALC) ||
                 (r_state == S_FIX)  || ((r_state == S_IDLE) && Start);
  assign Busy        = (r_state != S_IDLE);
  assign Done        = r_done;
  assign RegWriteOut = r_done;
  assign ResultOut   = r_result;
  assign WriteRegOut = r_wreg;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_seq
// Description : Self-checking bench for ex_muldiv_seq. Directed cases plus
//               randomized ops compared against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] ReadData1in;
  logic [31:0] ReadData2in;
  logic [4:0]  WriteRegIn;
  logic        Flush;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultOut;
  logic [4:0]  WriteRegOut;
  logic        RegWriteOut;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_seq #(.XLEN(32), .REGW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Funct3      (Funct3),
    .ReadData1in (ReadData1in),
    .ReadData2in (ReadData2in),
    .WriteRegIn  (WriteRegIn),
    .Flush       (Flush),
    .Stall       (Stall),
    .Busy        (Busy),
    .Done        (Done),
    .ResultOut   (ResultOut),
    .WriteRegOut (WriteRegOut),
    .RegWriteOut (RegWriteOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit / integer arithmetic from the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa64, sb64, za64, zb64, p;
    int          si, sj;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    za64 = {32'd0, a};
    zb64 = {32'd0, b};
    si   = $signed(a);
    sj   = $signed(b);
    p    = '0;
    case (f3)
      3'd0: begin p = sa64 * sb64; return p[31:0];  end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * zb64; return p[63:32]; end
      3'd3: begin p = za64 * zb64; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(si / sj);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(si % sj);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycle (counting the issue cycle as 0) in which Done is expected.
  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2]) begin
      if (b == 32'd0) return 2;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 35;
`endif
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input string tag);
    logic [31:0] exp;
    int          lat;
    int          c;
    bit          bad;
    bit          got_done;
    exp = ref_result(f3, a, b);
    lat = ref_latency(f3, a, b);
    @(negedge clk);
    Start = 1'b1; Funct3 = f3; ReadData1in = a; ReadData2in = b; WriteRegIn = rd;
    #1 check({tag, "_stall_issue"}, 64'(Stall), 64'd1);
    @(posedge clk);
    bad = 1'b0; got_done = 1'b0; c = 0;
    while (c < 60 && !got_done) begin
      @(negedge clk);
      c++;
      // Scramble inputs: the unit must work from its captured copies.
      Start = 1'b0; Funct3 = 3'($urandom); ReadData1in = $urandom;
      ReadData2in = $urandom; WriteRegIn = 5'($urandom);
      if (Done) got_done = 1'b1;
      else if (!Stall || !Busy) bad = 1'b1;
    end
    if (!got_done) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(c), 64'(lat));
      check({tag, "_result"}, 64'(ResultOut), 64'(exp));
      check({tag, "_wreg"}, 64'(WriteRegOut), 64'(rd));
      check({tag, "_regwrite"}, 64'(RegWriteOut), 64'd1);
      check({tag, "_stall_done"}, 64'(Stall), 64'd0);
      check({tag, "_stall_hold"}, 64'(bad), 64'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(Done), 64'd0);
      check({tag, "_busy_after"}, 64'(Busy), 64'd0);
      check({tag, "_result_hold"}, 64'(ResultOut), 64'(exp));
    end
  endtask

  initial begin
    bit         seen;
    logic [2:0] f3;
    logic [31:0] a, b;
    int          mode;

    rst_n = 1'b0; Start = 1'b0; Funct3 = '0; ReadData1in = '0;
    ReadData2in = '0; WriteRegIn = '0; Flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_stall", 64'(Stall), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_result", 64'(ResultOut), 64'd0);
    check("reset_wreg", 64'(WriteRegOut), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  "mul");
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd7,  "mulhsu");
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd8,  "mulh");
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  "div");
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, "rem");
    do_op(3'd5, 32'd100,        32'd7,         5'd11, "divu");
    do_op(3'd7, 32'd100,        32'd7,         5'd12, "remu");
    do_op(3'd5, 32'd5,          32'd0,         5'd13, "divu_zero");
    do_op(3'd6, 32'd5,          32'd0,         5'd14, "rem_zero");
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, "div_ovf");
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, "rem_ovf");

    // Flush mid-CALC: issue at cycle 0, Flush in cycle 10, IDLE in cycle 11
    seen = 1'b0;
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd4; ReadData1in = 32'd1000; ReadData2in = 32'd3;
    WriteRegIn = 5'd20;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      Start = 1'b0;
      if (Done) seen = 1'b1;
    end
    check("flush_busy_before", 64'(Busy), 64'd1);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    if (Done) seen = 1'b1;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_stall", 64'(Stall), 64'd0);
    check("flush_no_done", 64'(seen), 64'd0);
    do_op(3'd5, 32'd1000, 32'd3, 5'd21, "after_flush");

    // Flush takes priority over a same-cycle Start
    seen = 1'b0;
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'd0; ReadData1in = 32'd3;
    ReadData2in = 32'd3; WriteRegIn = 5'd22;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_prio_busy", 64'(Busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    check("flush_prio_quiet", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC
    do_op(3'd7, 32'd100, 32'd7, 5'd3, "pre_reset");
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd4; ReadData1in = 32'd12345; ReadData2in = 32'd17;
    WriteRegIn = 5'd23;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_stall", 64'(Stall), 64'd0);
    check("arst_done", 64'(Done), 64'd0);
    check("arst_regwrite", 64'(RegWriteOut), 64'd0);
    check("arst_result", 64'(ResultOut), 64'd0);
    check("arst_wreg", 64'(WriteRegOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    check("arst_quiet", 64'(seen), 64'd0);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin
        a = $urandom_range(0, 200);
        b = $urandom_range(1, 15);
      end
      do_op(f3, a, b, 5'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
